// File: rtl/dcache_pkg.sv
// Shared geometry, FSM state encoding and address-field helpers for the
// direct-mapped write-back data cache.
package dcache_pkg;

  localparam int ADDR_W     = 32;
  localparam int LINE_BYTES = 32;
  localparam int NUM_LINES  = 16;

  localparam int OFFSET_W   = $clog2(LINE_BYTES);
  localparam int INDEX_W    = $clog2(NUM_LINES);
  localparam int TAG_W      = ADDR_W - OFFSET_W - INDEX_W;
  localparam int LINE_W     = 8 * LINE_BYTES;
  localparam int WSEL_W     = OFFSET_W - 2;

  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [TAG_W-1:0]   tag_t;
  typedef logic [INDEX_W-1:0] index_t;
  typedef logic [WSEL_W-1:0]  wsel_t;
  typedef logic [LINE_W-1:0]  line_t;

  typedef logic [1:0] state_t;
  localparam state_t IDLE      = 2'd0;
  localparam state_t WRITEBACK = 2'd1;
  localparam state_t ALLOCATE  = 2'd2;
  localparam state_t REFILLED  = 2'd3;

  function automatic tag_t get_tag(input addr_t a);
    return a[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic index_t get_index(input addr_t a);
    return a[OFFSET_W +: INDEX_W];
  endfunction

  function automatic wsel_t get_wsel(input addr_t a);
    return a[2 +: WSEL_W];
  endfunction

  function automatic addr_t line_addr(input tag_t t, input index_t i);
    return {t, i, {OFFSET_W{1'b0}}};
  endfunction

  function automatic logic [31:0] line_word(input line_t l, input wsel_t w);
    return l[32*w +: 32];
  endfunction

  function automatic line_t merge_word(input line_t l, input wsel_t w, input logic [31:0] d);
    line_t r;
    r = l;
    r[32*w +: 32] = d;
    return r;
  endfunction

endpackage

// File: rtl/dcache_if.sv
// CPU-side and backing-memory-side signal bundle of the data cache.
interface dcache_if;

  logic                              cpu_req_i;
  logic                              cpu_we_i;
  logic [dcache_pkg::ADDR_W-1:0]     cpu_addr_i;
  logic [31:0]                       cpu_data_i;
  logic [31:0]                       cpu_data_o;
  logic                              cpu_stall_o;
  logic                              mem_req_o;
  logic                              mem_we_o;
  logic [dcache_pkg::ADDR_W-1:0]     mem_addr_o;
  logic [dcache_pkg::LINE_W-1:0]     mem_data_o;
  logic                              mem_ack_i;
  logic [dcache_pkg::LINE_W-1:0]     mem_data_i;

  modport slave (
    input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_data_i, mem_ack_i, mem_data_i,
    output cpu_data_o, cpu_stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_data_o
  );

  modport master (
    output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_data_i, mem_ack_i, mem_data_i,
    input  cpu_data_o, cpu_stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_data_o
  );

endinterface

// File: rtl/dcache_sram.sv
// Line storage: valid/dirty/tag/data with one asynchronous read port and one
// synchronous whole-entry write port. Reset clears only valid and dirty.
module dcache_sram
  import dcache_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_i,
  input  index_t rd_idx,
  output logic   rd_valid,
  output logic   rd_dirty,
  output tag_t   rd_tag,
  output line_t  rd_line,
  input  logic   wr_en,
  input  index_t wr_idx,
  input  tag_t   wr_tag,
  input  line_t  wr_line,
  input  logic   wr_valid,
  input  logic   wr_dirty
);

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  tag_t                 tag_q  [NUM_LINES];
  line_t                data_q [NUM_LINES];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= wr_valid;
      dirty_q[wr_idx] <= wr_dirty;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_line;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_dirty = dirty_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_line  = data_q[rd_idx];

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate data cache: combinational hits in
// the MEM cycle, pipeline stall while the miss FSM writes back and refills.
module dcache_controller
  import dcache_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_i,
  dcache_if.slave  bus
);

  state_t state_q, state_d;
  addr_t  miss_addr_q;

  logic   idle;
  logic   hit;
  index_t rd_idx;
  logic   rd_valid, rd_dirty;
  tag_t   rd_tag;
  line_t  rd_line;

  logic   wr_en;
  tag_t   wr_tag;
  line_t  wr_line;
  logic   wr_valid, wr_dirty;

  assign idle   = (state_q == IDLE);
  // While a miss is in flight the array is addressed by the captured miss,
  // so a wandering cpu_addr_i cannot redirect the write-back or refill.
  assign rd_idx = idle ? get_index(bus.cpu_addr_i) : get_index(miss_addr_q);
  assign hit    = rd_valid & (rd_tag == get_tag(bus.cpu_addr_i));

  dcache_sram u_sram (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .rd_idx   (rd_idx),
    .rd_valid (rd_valid),
    .rd_dirty (rd_dirty),
    .rd_tag   (rd_tag),
    .rd_line  (rd_line),
    .wr_en    (wr_en),
    .wr_idx   (rd_idx),
    .wr_tag   (wr_tag),
    .wr_line  (wr_line),
    .wr_valid (wr_valid),
    .wr_dirty (wr_dirty)
  );

  assign bus.cpu_stall_o = rst_i & bus.cpu_req_i & (~hit | ~idle);
  assign bus.cpu_data_o  = (rst_i & idle & bus.cpu_req_i & ~bus.cpu_we_i & hit)
                           ? line_word(rd_line, get_wsel(bus.cpu_addr_i)) : 32'd0;

  assign bus.mem_req_o   = (state_q == WRITEBACK) | (state_q == ALLOCATE);
  assign bus.mem_we_o    = (state_q == WRITEBACK);
  assign bus.mem_data_o  = rd_line;
  assign bus.mem_addr_o  = (state_q == WRITEBACK) ? line_addr(rd_tag, get_index(miss_addr_q)) :
                           (state_q == ALLOCATE)  ? line_addr(get_tag(miss_addr_q), get_index(miss_addr_q)) :
                           '0;

  always_comb begin
    state_d  = state_q;
    wr_en    = 1'b0;
    wr_tag   = rd_tag;
    wr_line  = rd_line;
    wr_valid = rd_valid;
    wr_dirty = rd_dirty;
    case (state_q)
      IDLE: begin
        if (bus.cpu_req_i) begin
          if (hit) begin
            if (bus.cpu_we_i) begin
              wr_en    = 1'b1;
              wr_line  = merge_word(rd_line, get_wsel(bus.cpu_addr_i), bus.cpu_data_i);
              wr_dirty = 1'b1;
            end
          end else begin
            state_d = (rd_valid & rd_dirty) ? WRITEBACK : ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        if (bus.mem_ack_i) begin
          wr_en    = 1'b1;
          wr_dirty = 1'b0;
          state_d  = ALLOCATE;
        end
      end
      ALLOCATE: begin
        if (bus.mem_ack_i) begin
          wr_en    = 1'b1;
          wr_tag   = get_tag(miss_addr_q);
          wr_line  = bus.mem_data_i;
          wr_valid = 1'b1;
          wr_dirty = 1'b0;
          state_d  = REFILLED;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (idle & bus.cpu_req_i & ~hit) miss_addr_q <= bus.cpu_addr_i;
  end

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate data cache.
- Sits between the MEM stage (EX_MEM outputs: ALU result as address, MemRead/MemWrite, store data) and a slow line-wide backing memory.
- Hits complete combinationally in the MEM cycle.
- On a miss, cpu_stall_o freezes the whole pipeline while an FSM writes back the dirty victim, then refills the line.

Parameters:
- ADDR_W, 32, byte address width.
- LINE_BYTES, 32, bytes per line (256-bit line, 8 words).
- NUM_LINES, 16, number of lines.
- Derived: OFFSET_W = log2(LINE_BYTES) = 5; INDEX_W = log2(NUM_LINES) = 4; TAG_W = ADDR_W-OFFSET_W-INDEX_W = 23.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  asynchronous active-low reset.
- cpu_req_i  in  1  access request (MemRead | MemWrite).
- cpu_we_i  in  1  1 = store, 0 = load.
- cpu_addr_i  in  ADDR_W  byte address; bits [1:0] ignored.
- cpu_data_i  in  32  store data.
- cpu_data_o  out  32  load data, valid when cpu_req_i & ~cpu_we_i & ~cpu_stall_o.
- cpu_stall_o  out  1  freeze PC, IF_ID, ID_EX, EX_MEM, MEM_WB.
- mem_req_o  out  1  backing-memory request, held until ack.
- mem_we_o  out  1  1 = line write-back, 0 = line fetch.
- mem_addr_o  out  ADDR_W  line-aligned address (low OFFSET_W bits 0).
- mem_data_o  out  8*LINE_BYTES  victim line for write-back.
- mem_ack_i  in  1  one-cycle completion pulse.
- mem_data_i  in  8*LINE_BYTES  fetched line, valid with mem_ack_i.

Behaviour:
- Address fields:
  - word select = addr[OFFSET_W-1:2]
  - index = addr[OFFSET_W+INDEX_W-1:OFFSET_W]
  - tag = addr[ADDR_W-1:OFFSET_W+INDEX_W]
- Per line state: valid, dirty, tag, data.
- hit = valid[index] & (tag[index] == addr tag).
- Reset (rst_i low, asynchronous):
  - all valid and dirty bits cleared; state = IDLE.
  - mem_req_o = 0, mem_we_o = 0, cpu_stall_o = 0, cpu_data_o = 0.
  - Reset mid-transaction aborts it immediately: no write-back, partial refill discarded.
- cpu_stall_o = cpu_req_i & (~hit | state != IDLE), combinational.
- IDLE:
  - Load hit: cpu_data_o = selected word, same cycle, no stall.
  - Store hit: at the clock edge, write the word and set dirty.
  - Miss with victim valid & dirty → WRITEBACK. Otherwise → ALLOCATE.
  - Capture the miss address on entry.
- WRITEBACK:
  - mem_req_o = 1, mem_we_o = 1.
  - mem_addr_o = {victim tag, index, 0}; mem_data_o = victim line.
  - On mem_ack_i: clear dirty → ALLOCATE.
- ALLOCATE:
  - mem_req_o = 1, mem_we_o = 0, mem_addr_o = {miss tag, index, 0}.
  - On mem_ack_i: write mem_data_i into the line; set tag; valid = 1; dirty = 0 → REFILLED.
- REFILLED:
  - mem_req_o = 0; return to IDLE next cycle.
  - The held request is then evaluated as a hit: the load returns data or the store merges and sets dirty, and the stall drops in that cycle.
- Latency:
  - Clean miss = mem latency + 2 cycles of stall.
  - Dirty miss adds one full write-back transaction.
- mem_req_o deasserts the cycle after mem_ack_i is sampled.
- mem_ack_i is ignored outside WRITEBACK/ALLOCATE.
- The CPU holds cpu_* inputs stable while stalled. The controller uses the captured miss address for all memory addresses, so input glitches cannot corrupt the refill.
- cpu_req_i low in IDLE: no state change, no stall.

Decomposition:
- Package dcache_pkg:
  - state enum {IDLE, WRITEBACK, ALLOCATE, REFILLED};
  - OFFSET_W, INDEX_W, TAG_W and LINE_W localparams;
  - field-extract functions.
- One sub-module, dcache_sram:
  - valid/dirty/tag/data arrays with asynchronous read and synchronous write;
  - reset clears valid/dirty only.
- The FSM and hit logic stay in dcache_controller.

Test Plan:
1. Reset, load 0x0000_0400:
   - stall = 1; mem_req_o = 1, mem_we_o = 0, mem_addr_o = 0x400.
   - Ack 3 cycles later with word0 = 0x11111111.
   - Two cycles later stall = 0 and cpu_data_o = 0x11111111.
2. Load 0x0000_0404 after test 1 → no stall, cpu_data_o = word1 of refilled line in the same cycle, mem_req_o stays 0.
3. Store 0xDEADBEEF to 0x0000_0408 → no stall; a following load of 0x408 returns 0xDEADBEEF; dirty[0] = 1.
4. Load 0x0000_0600 (index 0, conflicting tag) after test 3:
   - WRITEBACK: mem_we_o = 1, mem_addr_o = 0x400, mem_data_o word2 = 0xDEADBEEF.
   - Then ALLOCATE: mem_addr_o = 0x600.
   - Final load returns the new line's word0.
5. Store miss to clean line 0x0000_0820:
   - ALLOCATE only, no write-back.
   - After refill the word is merged, dirty set, and a load of 0x820 returns the store data.
6. Drive rst_i low mid-ALLOCATE:
   - mem_req_o and cpu_stall_o drop without waiting for a clock; all lines invalid.
   - After release, a load of 0x404 misses again.
